// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath constants, types and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned HDR_W  = 4;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned WORD_W = HDR_W + DATA_W;

  localparam logic [HDR_W-1:0] BYPASS_HDR = 4'd10;
  localparam logic [HDR_W-1:0] NULL_HDR   = 4'd0;

  typedef logic [WORD_W-1:0] aes_word_t;
  typedef logic [DATA_W-1:0] aes_state_t;
  typedef logic [31:0]       aes_col_t;
  typedef logic [HDR_W-1:0]  aes_hdr_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} aes_fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Round-bus handshake bundle for the InvMixColumns stage.
interface inv_mix_columns_seq_if;

  logic              in_valid;
  logic              in_ready;
  aes_pkg::aes_word_t data_in;
  logic              out_valid;
  logic              out_ready;
  aes_pkg::aes_word_t data_out;
  logic              busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/inv_mix_column_32.sv
// Combinational InvMixColumns on one 32-bit column; row r lives in bits [r*8 +: 8].
module inv_mix_column_32
  import aes_pkg::*;
(
  input  aes_col_t col_in,
  output aes_col_t col_out
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col_in[7:0];
  assign s1 = col_in[15:8];
  assign s2 = col_in[23:16];
  assign s3 = col_in[31:24];

  assign col_out[7:0]   = gmul14(s0) ^ gmul11(s1) ^ gmul13(s2) ^ gmul9(s3);
  assign col_out[15:8]  = gmul9(s0)  ^ gmul14(s1) ^ gmul11(s2) ^ gmul13(s3);
  assign col_out[23:16] = gmul13(s0) ^ gmul9(s1)  ^ gmul14(s2) ^ gmul11(s3);
  assign col_out[31:24] = gmul11(s0) ^ gmul13(s1) ^ gmul9(s2)  ^ gmul14(s3);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns round stage, column-serial by default.
// Define INV_MIX_COLUMNS_PAR_EN to use four column engines and a single-cycle CALC.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  inv_mix_columns_seq_if.slave bus
);

  aes_fsm_e   state_q, state_d;
  aes_hdr_t   hdr_q, hdr_d;
  aes_state_t data_q, data_d;
  aes_state_t res_q, res_d;
  aes_state_t calc_res;
  logic       calc_last;

`ifdef INV_MIX_COLUMNS_PAR_EN
  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column_32 u_col (
      .col_in  (data_q[c*32 +: 32]),
      .col_out (calc_res[c*32 +: 32])
    );
  end

  assign calc_last = 1'b1;
`else
  logic [1:0] cnt_q, cnt_d;
  aes_col_t   col_in, col_out;

  assign col_in = data_q[{cnt_q, 5'd0} +: 32];

  inv_mix_column_32 u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_comb begin
    calc_res = res_q;
    calc_res[{cnt_q, 5'd0} +: 32] = col_out;
  end

  assign calc_last = (cnt_q == 2'd3);

  // Wraps 3 -> 0 on the last CALC cycle, so it is already zero for the next block.
  assign cnt_d = (state_q == CALC) ? cnt_q + 2'd1 : 2'd0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          hdr_d  = bus.data_in[DATA_W +: HDR_W];
          data_d = bus.data_in[DATA_W-1:0];
          // Seeding the result with the input makes bypass a plain jump to DONE.
          res_d  = bus.data_in[DATA_W-1:0];
          if (hdr_d == NULL_HDR) begin
            state_d = IDLE;
          end else if (hdr_d == BYPASS_HDR) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        res_d = calc_res;
        if (calc_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.data_out  = (state_q == DONE) ? {hdr_q, res_q} : '0;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- AES InvMixColumns stage for the decryption datapath; the inverse of the encrypt-side MixColumns transform.
- Operates on the 132-bit round bus: 4-bit round header in [131:128], 128-bit state in [127:0].
- Column-serial: one shared GF(2^8) column engine runs over 4 cycles, trading latency for area.
- Valid/ready handshakes on both sides.

Parameters:
- HDR_W, 4, round-header width.
- DATA_W, 128, state width.
- BYPASS_HDR, 10, header value for which the state passes through untransformed (final round).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  data_in holds a block.
- in_ready  out  1  block accepted when in_valid && in_ready.
- data_in  in  132  {header, state}.
- out_valid  out  1  data_out holds a result.
- out_ready  in  1  downstream accepts the result.
- data_out  out  132  {header, transformed state}; all zeros whenever out_valid=0.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Byte map: column c = state[c*32 +: 32]; row r of column c = state[c*32 + r*8 +: 8].
- Output row r = XOR over j of M[r][j]·s_j in GF(2^8), reduction polynomial 0x11B.
- M rows: {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- Reset: FSM=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0, data_out=0, column counter=0, internal registers cleared.
- IDLE: in_ready=1. On handshake, latch header and state, then branch on header:
  - 0: null token; discard, stay IDLE, no output.
  - BYPASS_HDR: go to DONE with the state unchanged.
  - otherwise: go to CALC with col_cnt=0.
- CALC: each cycle, transform column col_cnt into the result register, then col_cnt++. Leave for DONE after col_cnt=3, so CALC lasts exactly 4 cycles.
- DONE: out_valid=1; data_out={latched header, result}. Hold data_out stable while out_ready=0. On out_ready, go to IDLE next cycle.
- Latency, accept edge at cycle T:
  - compute: out_valid asserted at T+5;
  - bypass: out_valid asserted at T+1.
- Throughput: in_ready=0 outside IDLE, so there is no overlap. The minimum accept-to-accept interval is 6 cycles with out_ready tied high.
- Input changes while busy are ignored; only latched values are used.
- Async reset mid-CALC or mid-DONE: the block is dropped, outputs return to reset values immediately, and no partial result is ever emitted.
- Header is never altered. Header values 1–9 and 11–15 are all transformed identically.

Optional Feature:
- Macro: INV_MIX_COLUMNS_PAR_EN.
- Defined: four column engines; CALC lasts 1 cycle; compute latency is T+2.
- Undefined: single engine, 4-cycle CALC as above.
- Handshake, bypass, null-token and reset behaviour are identical either way.

Decomposition:
- Shared package aes_pkg:
  - HDR_W, DATA_W, BYPASS_HDR, NULL_HDR=0 constants;
  - typedefs aes_word_t (132b), aes_state_t (128b), aes_col_t (32b);
  - FSM enum {IDLE, CALC, DONE};
  - GF functions xtime(), gmul9/11/13/14().
- Sub-module inv_mix_column_32: purely combinational, aes_col_t in to aes_col_t out. Instantiated 1× by default, or 4× under INV_MIX_COLUMNS_PAR_EN.

Test Plan:
- FIPS-197 vector, all columns: header 4'h3, every column 32'hbca14d8e (rows 8e,4d,a1,bc), out_ready=1 → out_valid exactly 5 cycles after accept; data_out={4'h3, 4×32'h455313db}.
- Mixed columns: columns 0..3 = 32'h9d58dc9f, 32'hc6c6c6c6, 32'hd6d7d5d5, 32'h01010101, header 4'h7 → columns 32'h5c220af2, 32'hc6c6c6c6, 32'hd5d4d4d4, 32'h01010101.
- Bypass: header 4'd10, arbitrary state → out_valid at T+1; data_out equals data_in bit-for-bit.
- Null token: header 0 → consumed (in_ready=1 throughout), out_valid stays 0, busy stays 0. A following valid block is processed normally.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → data_out stable, in_ready=0, in_valid pulses ignored. Release → out_valid drops next cycle and in_ready rises.
- Reset mid-CALC: assert n_rst low during the 2nd CALC cycle → out_valid=0 and data_out=0 immediately. After release, a new block yields the correct result with no residue from the aborted one.
